// File: rtl/pow_pkg.sv
// Shared definitions for the square-and-multiply power unit and its multiplier.
package pow_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    WAIT_ACC = 3'd2,
    SQR_CHK  = 3'd3,
    WAIT_SQR = 3'd4,
    DONE     = 3'd5
  } pow_state_e;

  // The accumulator must be able to hold the zero-extended base.
  function automatic bit widths_ok(input int x_w, input int y_w);
    return (x_w > 0) && (y_w >= x_w);
  endfunction

endpackage

// File: rtl/pow_n_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, done_o exactly W cycles
// after the start cycle, product held until the next start.
module seq_mul #(
  parameter int W = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] y_bo
);

  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done;

  assign done = busy_q && (cnt_q == '0);

  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (start_i && (!busy_q || done)) begin
      // Bit 0 is folded into the load so W-1 further steps finish on time.
      prod_d   = b_bi[0] ? {{W{1'b0}}, a_bi} : '0;
      mcand_d  = {{W{1'b0}}, a_bi} << 1;
      mplier_d = b_bi >> 1;
      cnt_d    = CNT_W'(W - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done;
  assign y_bo   = prod_q;

endmodule

// File: rtl/pow_n.sv
// Sequential y = x^e via right-to-left square-and-multiply on one shared
// multiplier; result is x^e mod 2^Y_W with an overflow flag.
//
// state    | meaning
// IDLE     | waiting for start_i, outputs hold last result
// CHECK    | e_r==0 -> finish; odd -> launch acc*base
// WAIT_ACC | waiting for acc*base product
// SQR_CHK  | shift exponent; more bits -> launch base*base
// WAIT_SQR | waiting for base*base product
// DONE     | publish acc/ovf, pulse done_o
module pow_n
  import pow_pkg::*;
#(
  parameter int X_W = 8,
  parameter int E_W = 4,
  parameter int Y_W = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [X_W-1:0] x_bi,
  input  logic [E_W-1:0] e_bi,
  output logic           busy_o,
  output logic           done_o,
  output logic [Y_W-1:0] y_bo,
  output logic           ovf_o
);

  if (!widths_ok(X_W, Y_W)) begin : g_bad_widths
    $error("pow_n: Y_W must be at least X_W");
  end

  pow_state_e state_q, state_d;
  logic [Y_W-1:0] base_q, base_d;
  logic [Y_W-1:0] acc_q, acc_d;
  logic [E_W-1:0] e_q, e_d;
  logic           ovf_r_q, ovf_r_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           ovf_o_q, ovf_o_d;

  logic             mul_start;
  logic [Y_W-1:0]   mul_a;
  logic             mul_busy;
  logic             mul_done;
  logic [2*Y_W-1:0] mul_y;
  logic [E_W-1:0]   e_shr;

  assign e_shr = e_q >> 1;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    acc_d     = acc_q;
    e_d       = e_q;
    ovf_r_d   = ovf_r_q;
    y_d       = y_q;
    ovf_o_d   = ovf_o_q;
    mul_start = 1'b0;
    mul_a     = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = Y_W'(x_bi);
          e_d     = e_bi;
          acc_d   = Y_W'(1);
          ovf_r_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (e_q == '0) begin
          state_d = DONE;
        end else if (e_q[0]) begin
          if (!mul_busy) begin
            mul_start = 1'b1;
            state_d   = WAIT_ACC;
          end
        end else begin
          state_d = SQR_CHK;
        end
      end
      WAIT_ACC: begin
        if (mul_done) begin
          acc_d   = mul_y[Y_W-1:0];
          ovf_r_d = ovf_r_q | (|mul_y[2*Y_W-1:Y_W]);
          state_d = SQR_CHK;
        end
      end
      SQR_CHK: begin
        // The final square would never be consumed, so it is skipped.
        if (e_shr == '0) begin
          e_d     = e_shr;
          state_d = DONE;
        end else if (!mul_busy) begin
          e_d       = e_shr;
          mul_start = 1'b1;
          mul_a     = base_q;
          state_d   = WAIT_SQR;
        end
      end
      WAIT_SQR: begin
        if (mul_done) begin
          base_d  = mul_y[Y_W-1:0];
          ovf_r_d = ovf_r_q | (|mul_y[2*Y_W-1:Y_W]);
          state_d = CHECK;
        end
      end
      DONE: begin
        y_d     = acc_q;
        ovf_o_d = ovf_r_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      e_q     <= '0;
      ovf_r_q <= 1'b0;
      y_q     <= '0;
      ovf_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      ovf_r_q <= ovf_r_d;
      y_q     <= y_d;
      ovf_o_q <= ovf_o_d;
    end
  end

  seq_mul #(.W(Y_W)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (mul_a),
    .b_bi    (base_q),
    .start_i (mul_start),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .y_bo    (mul_y)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign y_bo   = y_q;
  assign ovf_o  = ovf_o_q;

endmodule
